// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath/memory.
// The controller is the master: it samples opcode and mem_ready and
// drives every datapath enable, mux select and the illegal-opcode flag.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for a classic multicycle MIPS-style datapath
// (lw, sw, R-type, beq, j, optionally addi).
// Build option: define ADDI_SUPPORT_EN to add the addi path through
// ADDI_EXEC/ADDI_WB; without it opcode 001000 is reported as illegal.
// All outputs are forced low while rst_n is low, independent of clk,
// so an in-flight memory write is dropped the moment reset asserts.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_control_if.master bus,
  output logic [STATE_W-1:0] state
);

  if (STATE_W < 4) begin : g_bad_state_w
    $error("multicycle_control: STATE_W must be at least 4");
  end

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t state_d;

  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       mem_to_reg_c;
  logic       reg_dst_c;
  logic       reg_write_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic [1:0] pc_source_c;
  logic       illegal_op_c;

  // State register; reset parks the controller in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs; anything not driven in a state stays 0.
  always_comb begin
    state_d         = S_FETCH;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    illegal_op_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
`ifdef ADDI_SUPPORT_EN
          OP_ADDI:       state_d = S_ADDI_EXEC;
`endif
          default: begin
            state_d      = S_FETCH;
            illegal_op_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        state_d     = S_FETCH;
      end
`ifdef ADDI_SUPPORT_EN
      S_ADDI_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset gates every output so nothing reaches the datapath while rst_n is low.
  assign bus.pc_write      = rst_n & pc_write_c;
  assign bus.pc_write_cond = rst_n & pc_write_cond_c;
  assign bus.i_or_d        = rst_n & i_or_d_c;
  assign bus.mem_read      = rst_n & mem_read_c;
  assign bus.mem_write     = rst_n & mem_write_c;
  assign bus.ir_write      = rst_n & ir_write_c;
  assign bus.mem_to_reg    = rst_n & mem_to_reg_c;
  assign bus.reg_dst       = rst_n & reg_dst_c;
  assign bus.reg_write     = rst_n & reg_write_c;
  assign bus.alu_src_a     = rst_n & alu_src_a_c;
  assign bus.alu_src_b     = {2{rst_n}} & alu_src_b_c;
  assign bus.alu_op        = {2{rst_n}} & alu_op_c;
  assign bus.pc_source     = {2{rst_n}} & pc_source_c;
  assign bus.illegal_op    = rst_n & illegal_op_c;

  assign state = STATE_W'(state_q);

endmodule
